// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the rv_fetch instruction-fetch front end.
package rv_fetch_pkg;

    localparam int unsigned PC_W    = 30;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t; clear has priority over push/pop.
module rv_fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push & ~full & ~clear;
        do_pop  = pop & ~empty & ~clear;
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rv_fetch.sv
// Instruction-fetch front end: bus requester, prefetch FIFO and decode output register.
// Optional statistics counters are enabled with RV_FETCH_STAT_EN.
module rv_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [29:0] i_target,
    output logic        o_bus_req,
    output logic [29:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_data,
    output logic [31:0] o_data,
    output logic [29:0] o_pc,
    output logic [29:0] o_pc_p4,
    output logic        o_valid
`ifdef RV_FETCH_STAT_EN
    ,
    output logic [31:0] o_stat_fetched,
    output logic [31:0] o_stat_bubbles
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

    logic           stale;
    logic [29:0]    redirect;
    logic           ack;
    logic           accept;
    logic           bypass;
    logic           fifo_push;
    logic           fifo_pop;
    logic           load_entry;
    logic           req_next;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           full;
    logic           empty;
    fetch_entry_t   bus_entry;
    fetch_entry_t   head;
    fetch_entry_t   out_src;

    rv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .clear (i_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // An ack with an empty FIFO and no stall skips the FIFO and lands directly in the output register.
    always_comb begin
        ack        = i_bus_ack & o_bus_req;
        accept     = ack & ~stale & ~i_flush;
        bus_entry  = '{instr: i_bus_data, pc: o_bus_addr};
        bypass     = accept & empty & ~i_stall;
        fifo_push  = accept & ~bypass & ~full;
        fifo_pop   = ~i_flush & ~i_stall & ~empty;
        load_entry = fifo_pop | bypass;
        out_src    = empty ? bus_entry : head;
        count_next = i_flush ? '0 : count + CW'(fifo_push) - CW'(fifo_pop);
        req_next   = (o_bus_req & ~ack) | (count_next < CW'(FIFO_DEPTH));
    end

    // Request side: a flushed in-flight request completes as stale before switching to the redirect.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_bus_req  <= 1'b0;
            o_bus_addr <= RESET_WORD;
            stale      <= 1'b0;
            redirect   <= RESET_WORD;
        end else begin
            o_bus_req <= req_next;
            if (i_flush) begin
                redirect <= i_target;
                if (o_bus_req & ~ack) begin
                    stale <= 1'b1;
                end else begin
                    stale      <= 1'b0;
                    o_bus_addr <= i_target;
                end
            end else if (ack) begin
                stale      <= 1'b0;
                o_bus_addr <= stale ? redirect : pc_inc(o_bus_addr);
            end
        end
    end

    // Decode-facing output register; pc holds across bubbles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data  <= RV_NOP;
            o_pc    <= RESET_WORD;
            o_pc_p4 <= pc_inc(RESET_WORD);
            o_valid <= 1'b0;
        end else if (i_flush) begin
            o_data  <= RV_NOP;
            o_valid <= 1'b0;
        end else if (!i_stall) begin
            if (load_entry) begin
                o_data  <= out_src.instr;
                o_pc    <= out_src.pc;
                o_pc_p4 <= pc_inc(out_src.pc);
                o_valid <= 1'b1;
            end else begin
                o_data  <= RV_NOP;
                o_valid <= 1'b0;
            end
        end
    end

`ifdef RV_FETCH_STAT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stat_fetched <= '0;
            o_stat_bubbles <= '0;
        end else begin
            if (ack & ~stale) o_stat_fetched <= o_stat_fetched + 32'd1;
            if (!i_stall && (i_flush || !load_entry)) o_stat_bubbles <= o_stat_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_fetch.sv
// Directed self-checking bench for rv_fetch (RESET_PC=0x100, FIFO_DEPTH=4).
module tb_rv_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] target = '0;
    logic        ack_en = 1'b0;
    logic        bus_req;
    logic [29:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_data;
    logic [31:0] o_data;
    logic [29:0] o_pc;
    logic [29:0] o_pc_p4;
    logic        o_valid;
`ifdef RV_FETCH_STAT_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_bubbles;
`endif

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;

    rv_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_stall    (stall),
        .i_flush    (flush),
        .i_target   (target),
        .o_bus_req  (bus_req),
        .o_bus_addr (bus_addr),
        .i_bus_ack  (bus_ack),
        .i_bus_data (bus_data),
        .o_data     (o_data),
        .o_pc       (o_pc),
        .o_pc_p4    (o_pc_p4),
        .o_valid    (o_valid)
`ifdef RV_FETCH_STAT_EN
        ,
        .o_stat_fetched (stat_fetched),
        .o_stat_bubbles (stat_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // Slave model: zero-wait ack when enabled, word derived from the address.
    assign bus_ack  = ack_en & bus_req;
    assign bus_data = {bus_addr, 2'b11};

    always @(negedge clk) begin
        if (rst) ack_cnt = 0;
        else if (bus_ack) ack_cnt = ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; stall = 1'b0; ack_en = 1'b0; target = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", bus_req); end
        checks++; if (bus_addr !== 30'h40) begin failures++; $display("FAIL reset_addr got=%0h exp=40", bus_addr); end
        checks++; if (o_data !== 32'h13) begin failures++; $display("FAIL reset_data got=%0h exp=13", o_data); end
        checks++; if (o_pc !== 30'h40) begin failures++; $display("FAIL reset_pc got=%0h exp=40", o_pc); end
        checks++; if (o_pc_p4 !== 30'h41) begin failures++; $display("FAIL reset_pc_p4 got=%0h exp=41", o_pc_p4); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", o_valid); end
        ack_en = 1'b1;
        tick();
        checks++; if (bus_req !== 1'b1 || bus_addr !== 30'h40 || o_valid !== 1'b0) begin failures++; $display("FAIL first_req req=%0h addr=%0h valid=%0h exp 1/40/0", bus_req, bus_addr, o_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus_addr !== 30'h41 + 30'(i) || bus_req !== 1'b1) begin failures++; $display("FAIL stream_addr%0d got=%0h/%0h exp=%0h/1", i, bus_addr, bus_req, 30'h41 + 30'(i)); end
            checks++; if (o_valid !== 1'b1 || o_pc !== 30'h40 + 30'(i) || o_pc_p4 !== 30'h41 + 30'(i)) begin failures++; $display("FAIL stream_out%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, o_valid, o_pc, o_pc_p4, 30'h40 + 30'(i), 30'h41 + 30'(i)); end
            checks++; if (o_data !== {30'h40 + 30'(i), 2'b11}) begin failures++; $display("FAIL stream_data%0d got=%0h exp=%0h", i, o_data, {30'h40 + 30'(i), 2'b11}); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1; ack_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (o_data !== 32'h13 || o_valid !== 1'b0) begin failures++; $display("FAIL stall_frozen%0d got=%0h/%0h exp=13/0", i, o_data, o_valid); end
        end
        checks++; if (ack_cnt !== 4) begin failures++; $display("FAIL stall_acks got=%0d exp=4", ack_cnt); end
        checks++; if (bus_req !== 1'b0 || bus_addr !== 30'h44) begin failures++; $display("FAIL stall_full_req got=%0h/%0h exp=0/44", bus_req, bus_addr); end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (o_valid !== 1'b1 || o_pc !== 30'h40 + 30'(i) || o_data !== {30'h40 + 30'(i), 2'b11}) begin failures++; $display("FAIL stall_drain%0d got=%0h/%0h/%0h exp=1/%0h", i, o_valid, o_pc, o_data, 30'h40 + 30'(i)); end
        end
    endtask

    task automatic test_flush_pending();
        do_reset();
        ack_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (bus_addr !== 30'h45 || bus_req !== 1'b1 || o_pc !== 30'h44) begin failures++; $display("FAIL flush_setup got=%0h/%0h/%0h exp=45/1/44", bus_addr, bus_req, o_pc); end
        ack_en = 1'b0; flush = 1'b1; target = 30'h200;
        tick();
        flush = 1'b0;
        checks++; if (bus_addr !== 30'h45 || bus_req !== 1'b1) begin failures++; $display("FAIL flush_hold_req got=%0h/%0h exp=45/1", bus_addr, bus_req); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (o_valid !== 1'b0 || o_data !== 32'h13) begin failures++; $display("FAIL flush_bubble%0d got=%0h/%0h exp=0/13", i, o_valid, o_data); end
            tick();
        end
        ack_en = 1'b1;
        tick();
        checks++; if (bus_addr !== 30'h200 || bus_req !== 1'b1 || o_valid !== 1'b0 || o_data !== 32'h13) begin failures++; $display("FAIL flush_stale_drop got=%0h/%0h/%0h/%0h exp=200/1/0/13", bus_addr, bus_req, o_valid, o_data); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 30'h200 || o_pc_p4 !== 30'h201 || o_data !== 32'h803) begin failures++; $display("FAIL flush_target_out got=%0h/%0h/%0h/%0h exp=1/200/201/803", o_valid, o_pc, o_pc_p4, o_data); end
        checks++; if (bus_addr !== 30'h201) begin failures++; $display("FAIL flush_next_addr got=%0h exp=201", bus_addr); end
    endtask

    task automatic test_flush_with_ack();
        do_reset();
        ack_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1; target = 30'h300;
        tick();
        flush = 1'b0;
        checks++; if (bus_addr !== 30'h300 || bus_req !== 1'b1 || o_valid !== 1'b0 || o_data !== 32'h13) begin failures++; $display("FAIL flush_ack_redirect got=%0h/%0h/%0h/%0h exp=300/1/0/13", bus_addr, bus_req, o_valid, o_data); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 30'h300 || o_data !== 32'hC03) begin failures++; $display("FAIL flush_ack_out got=%0h/%0h/%0h exp=1/300/c03", o_valid, o_pc, o_data); end
        checks++; if (bus_addr !== 30'h301) begin failures++; $display("FAIL flush_ack_next got=%0h exp=301", bus_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        ack_en = 1'b1;
        tick();
        flush = 1'b1; target = 30'h3FFF_FFFF;
        tick();
        flush = 1'b0;
        checks++; if (bus_addr !== 30'h3FFF_FFFF) begin failures++; $display("FAIL wrap_setup got=%0h exp=3fffffff", bus_addr); end
        tick();
        checks++; if (bus_addr !== 30'h0) begin failures++; $display("FAIL wrap_addr got=%0h exp=0", bus_addr); end
        checks++; if (o_valid !== 1'b1 || o_pc !== 30'h3FFF_FFFF || o_pc_p4 !== 30'h0) begin failures++; $display("FAIL wrap_pc got=%0h/%0h/%0h exp=1/3fffffff/0", o_valid, o_pc, o_pc_p4); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 30'h0 || o_pc_p4 !== 30'h1 || o_data !== 32'h3) begin failures++; $display("FAIL wrap_next got=%0h/%0h/%0h/%0h exp=1/0/1/3", o_valid, o_pc, o_pc_p4, o_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ack_en = 1'b0;
        tick();
        checks++; if (bus_req !== 1'b1 || bus_addr !== 30'h42) begin failures++; $display("FAIL mid_pending got=%0h/%0h exp=1/42", bus_req, bus_addr); end
        rst = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0 || bus_addr !== 30'h40) begin failures++; $display("FAIL mid_reset_req got=%0h/%0h exp=0/40", bus_req, bus_addr); end
        checks++; if (o_data !== 32'h13 || o_valid !== 1'b0 || o_pc !== 30'h40 || o_pc_p4 !== 30'h41) begin failures++; $display("FAIL mid_reset_out got=%0h/%0h/%0h/%0h exp=13/0/40/41", o_data, o_valid, o_pc, o_pc_p4); end
        ack_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus_req !== 1'b1 || bus_addr !== 30'h40 || o_valid !== 1'b0) begin failures++; $display("FAIL mid_refetch_req got=%0h/%0h/%0h exp=1/40/0", bus_req, bus_addr, o_valid); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_pc !== 30'h40 || o_data !== 32'h103) begin failures++; $display("FAIL mid_refetch_out got=%0h/%0h/%0h exp=1/40/103", o_valid, o_pc, o_data); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_flush_pending();
        test_flush_with_ack();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_fetch.md
Name: rv_fetch

Overview:
- Instruction-fetch front end that feeds rv_decode: drives the instruction-bus request side, buffers returned words in a small prefetch FIFO, and presents one instruction per cycle as {o_data, o_pc, o_pc_p4}.
- Handles stall from the hazard unit and redirect/flush from the execute stage (taken branch, jal, jalr).
- Substitutes a NOP bubble whenever no valid instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] ignored.
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  asynchronous, active-high reset
- i_stall  in  1  decode stage stalled; hold outputs
- i_flush  in  1  redirect; same signal drives rv_decode i_flush
- i_target  in  30  redirect address [31:2], sampled when i_flush=1
- o_bus_req  out  1  instruction bus request
- o_bus_addr  out  30  request word address [31:2]
- i_bus_ack  in  1  request accepted; i_bus_data valid this cycle
- i_bus_data  in  32  instruction word
- o_data  out  32  instruction to decode
- o_pc  out  30  PC of o_data
- o_pc_p4  out  30  o_pc + 1 word
- o_valid  out  1  o_data is a fetched instruction (0 = bubble)

Behaviour:
- Reset values:
  - o_bus_req=0, o_bus_addr=RESET_PC[31:2]
  - o_data=32'h0000_0013 (NOP)
  - o_pc=RESET_PC[31:2], o_pc_p4=RESET_PC[31:2]+1
  - o_valid=0
  - FIFO empty, stale flag clear
- Bus protocol:
  - At most one outstanding request.
  - o_bus_req and o_bus_addr remain stable until i_bus_ack; no abort.
  - Ack and data arrive in the same cycle.
  - Back-to-back requests are allowed: on ack, o_bus_addr advances by 1 and o_bus_req stays high if space remains.
- Request enable: o_bus_req=1 only when fifo_count + (request pending ? 1 : 0) < FIFO_DEPTH.
- First request: o_bus_req asserts in the first cycle after reset deassertion.
- Ack handling:
  - Stale flag clear: push {i_bus_data, o_bus_addr} into the FIFO.
  - Stale flag set: discard the word and clear the flag.
- Output register:
  - Updates when i_stall=0.
  - FIFO non-empty: load the head entry, pop it, set o_valid=1.
  - FIFO empty: load NOP and o_valid=0; o_pc/o_pc_p4 hold their previous values.
- i_stall=1: output register and FIFO head hold; the fetch side continues until the FIFO is full.
- Bypass: an ack arriving while the FIFO is empty and i_stall=0 is pushed and visible at the output on the next cycle only (latency 1 clock from ack to o_data; no combinational bypass).
- Flush (priority over stall and over ack push):
  - FIFO cleared; output register loads NOP with o_valid=0.
  - Fetch address becomes i_target.
  - If a request is pending and not acked this cycle, set the stale flag; the address switches after that ack.
  - If no request is pending, or it is acked this cycle, the next request uses i_target on the following cycle.
  - A second flush while stale is set: the target is updated and the stale flag stays set (only one outstanding).
- PC arithmetic: 30-bit wrap; o_bus_addr 3FFF_FFFF+1 -> 0000_0000, with no error.
- FIFO full: no new request; any pending ack is guaranteed to have space by the request-enable rule.
- Async reset mid-transaction: all state returns to reset values immediately. The bus slave must also reset; an ack after reset with no request is ignored.

Optional Feature:
- Macro: RV_FETCH_STAT_EN.
- Defined:
  - Adds outputs o_stat_fetched[31:0] (count of non-stale acks) and o_stat_bubbles[31:0] (cycles with i_stall=0 and NOP loaded).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rv_fetch_pkg:
  - RV_NOP constant (32'h0000_0013)
  - fetch_entry_t struct {instr[31:0], pc[31:2]}
- Sub-module rv_fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, clear, count, full/empty, and async active-high reset.

Test Plan:
- Reset with RESET_PC=32'h100, slave acking every cycle -> o_bus_addr sequence 0x40,0x41,0x42; o_pc 0x40,0x41 with o_valid=1 starting the cycle after the first ack; o_pc_p4=o_pc+1.
- i_stall high for 6 cycles, slave always acking -> exactly FIFO_DEPTH=4 acks then o_bus_req=0; o_data frozen; after release, 4 consecutive valid outputs with no bubble.
- Flush with i_target=0x200 while a request at 0x45 is pending, ack 3 cycles later -> word at 0x45 dropped, next o_bus_addr=0x200, first valid o_pc=0x200, bubbles (o_valid=0, o_data=0x13) in between.
- Flush and ack in the same cycle -> acked word discarded, stale flag remains clear, next request at the target.
- o_bus_addr=0x3FFF_FFFF acked -> next o_bus_addr=0x0000_0000; o_pc_p4 of that entry=0.
- Assert i_reset between request and ack -> o_bus_req=0 immediately, outputs at reset values, refetch starts from RESET_PC.
